btb_table: RTL and testbench
============================

BTB_TABLE -- requirements
Module: btb_table

Interface
REQ-001 The block SHALL use these parameters: none; entry count fixed at 2048; entry width fixed at 16 bits.
REQ-002 The block SHALL expose these ports, clock and reset first:
 clk  input  1  single clock; all state updates on rising edge.
 rst_n  input  1  reset, asynchronous and active-low.
 clear  input  1  restart full-table invalidation sweep.
 r_en  input  1  fetch lookup request.
 r_pc  input  13  fetch PC (word address); index r_pc[10:0], tag r_pc[12:11].
 pred_pc  output  13  predicted next PC for the previous cycle's lookup.
 pred_hit  output  1  previous lookup hit a valid, tag-matching entry.
 ready  output  1  table initialised; lookups and writes serviced.
 w_data  input  16  update entry {valid, tag[1:0], target[12:0]} from the execute-stage PC calculator.
 w_addr  input  11  update index.
 wen  input  1  update strobe.
REQ-003 One clock and reset: rst_n is asynchronous and active-low; no other clock or reset exists.

Function
REQ-004 The table SHALL be 2048 x 16-bit storage, one write port, one synchronous read port.
REQ-005 The block SHALL implement a two-state FSM: INIT, RUN.
REQ-006 In INIT, an 11-bit sweep counter SHALL write 16'h0000 to entry[counter] each cycle and increment; ready=0.
REQ-007 When the counter equals 11'h7FF and is written, FSM SHALL move to RUN next cycle; counter wraps to 0.
REQ-008 In RUN, ready=1; clear=1 SHALL return FSM to INIT with counter 0 on the next edge.
REQ-009 clear in INIT SHALL restart the sweep at counter 0.
REQ-010 In RUN, wen=1 SHALL write w_data to entry[w_addr] at the rising edge; wen in INIT SHALL be dropped.
REQ-011 clear and wen in the same RUN cycle: the write SHALL be dropped; clear wins.
REQ-012 Lookup latency SHALL be exactly one cycle: r_en at edge N registers r_pc; pred_pc/pred_hit valid after edge N+1... i.e. during cycle N+1.
REQ-013 Hit SHALL be entry.valid==1 and entry.tag==r_pc[12:11]; pred_pc = hit ? entry.target : r_pc+1 (13-bit wrap, 13'h1FFF+1=0).
REQ-014 Lookup issued in INIT SHALL return pred_hit=0, pred_pc=r_pc+1.
REQ-015 r_en=0 SHALL hold pred_pc and pred_hit at their previous values.
REQ-016 Simultaneous wen and r_en to the same index: behaviour SHALL follow REQ-021.
REQ-017 The block SHALL not interpret w_data.valid; a write with valid=0 invalidates the entry.

Reset
REQ-018 On rst_n=0, immediately: FSM=INIT, counter=0, ready=0, pred_pc=13'h0000, pred_hit=0, registered lookup PC=0.
REQ-019 Table contents SHALL not be reset directly; the sweep after rst_n deassert SHALL invalidate them, ready rising 2048 cycles after the first edge with rst_n=1.
REQ-020 rst_n asserted mid-sweep or mid-lookup SHALL abort and restart per REQ-018.

Configuration
REQ-021 Macro BTB_BYPASS_EN: defined -> same-cycle write/lookup to the same index returns w_data's decoded result (write-first); undefined -> returns the old entry (read-first).
REQ-022 All other behaviour SHALL be identical with and without BTB_BYPASS_EN.

Verification
REQ-023 Reset, hold rst_n=1 -> ready=0 for 2048 cycles, 1 on cycle 2049; pred_hit=0 for any lookup meanwhile.
REQ-024 RUN, wen w_addr=11'h005 w_data={1,2'b01,13'h0123}; later r_pc=13'h0805 -> next cycle pred_hit=1, pred_pc=13'h0123; r_pc=13'h1005 -> pred_hit=0, pred_pc=13'h1006.
REQ-025 RUN, r_pc=13'h1FFF miss -> pred_pc=13'h0000.
REQ-026 Same cycle wen w_addr=11'h010 data={1,00,13'h0040}, r_en r_pc=13'h0010, entry previously invalid -> with BTB_BYPASS_EN pred_hit=1 pred_pc=13'h0040; without pred_hit=0 pred_pc=13'h0011.
REQ-027 RUN, clear with wen same cycle -> ready=0 next cycle, write dropped; after 2048 cycles lookup of that index misses.
REQ-028 rst_n pulsed low at sweep count 1000 -> all outputs reset at once, ready rises exactly 2048 cycles after release.

Source files
------------

// File: rtl/btb_table.sv
// ----------------------------------------------------------------------------
// btb_table - 2048-entry branch target buffer table.
//
// Each 16-bit entry is {valid, tag[1:0], target[12:0]}. The table has one write
// port and one synchronous read port. Its contents are never reset directly.
// Instead, an invalidation sweep writes zero to every entry after reset and
// after each clear. The sweep takes 2048 cycles, and ready is low while it runs.
//
// A lookup takes one cycle. When r_en is high at a rising edge, that edge
// captures r_pc and the addressed entry. During the following cycle, pred_hit
// and pred_pc show the decoded result. While r_en is low, both outputs hold
// their previous values.
//
// Configuration macro:
//   BTB_BYPASS_EN  defined   -> a same-cycle write and lookup to one index
//                               returns the new data (write-first).
//                  undefined -> the lookup returns the old entry (read-first).
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   clear     restart the full-table invalidation sweep
//   r_en      lookup request
//   r_pc      fetch PC (word address); index r_pc[10:0], tag r_pc[12:11]
//   pred_pc   predicted next PC for the previous lookup
//   pred_hit  previous lookup hit a valid, tag-matching entry
//   ready     sweep complete; lookups and writes are serviced
//   w_data    update entry {valid, tag[1:0], target[12:0]}
//   w_addr    update index
//   wen       update strobe
// ----------------------------------------------------------------------------
module btb_table (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        r_en,
    input  logic [12:0] r_pc,
    output logic [12:0] pred_pc,
    output logic        pred_hit,
    output logic        ready,
    input  logic [15:0] w_data,
    input  logic [10:0] w_addr,
    input  logic        wen
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e      state_q;
    logic [10:0] cnt_q;

    logic [15:0] mem [2048];

    // Lookup pipeline registers
    logic [12:0] pc_q;       // registered lookup PC
    logic        lk_vld_q;   // at least one lookup since reset
    logic        lk_run_q;   // last lookup was issued in StRun
    logic [15:0] rd_data_q;  // synchronous read data, not reset

    // Write port arbitration
    logic        run_we;     // accepted external update
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [10:0] rd_idx;
    logic [15:0] rd_data_d;

    assign rd_idx = r_pc[10:0];

    always_comb begin
        run_we    = (state_q == StRun) && wen && !clear;
        mem_we    = 1'b0;
        mem_addr  = cnt_q;
        mem_wdata = 16'h0000;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = 16'h0000;
        end else if (run_we) begin
            mem_we    = 1'b1;
            mem_addr  = w_addr;
            mem_wdata = w_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_idx];
`ifdef BTB_BYPASS_EN
        if (run_we && (w_addr == rd_idx)) begin
            rd_data_d = w_data;
        end
`endif
    end

    // Control FSM and sweep counter. A clear from either state restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= 11'h000;
        end else if (clear) begin
            state_q <= StInit;
            cnt_q   <= 11'h000;
        end else begin
            unique case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 11'h001;  // wraps to 0 after 11'h7FF
                    if (cnt_q == 11'h7FF) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q;
                end
                default: begin
                    state_q <= StInit;
                    cnt_q   <= 11'h000;
                end
            endcase
        end
    end

    // Table storage
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Read data register. It is kept out of reset so it can map onto the RAM output register.
    always_ff @(posedge clk) begin
        if (r_en) begin
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= 13'h0000;
            lk_vld_q <= 1'b0;
            lk_run_q <= 1'b0;
        end else if (r_en) begin
            pc_q     <= r_pc;
            lk_vld_q <= 1'b1;
            lk_run_q <= (state_q == StRun);
        end
    end

    // Outputs are decoded from the registered lookup. Before any lookup they sit at the reset value 0.
    always_comb begin
        pred_hit = lk_vld_q && lk_run_q && rd_data_q[15] && (rd_data_q[14:13] == pc_q[12:11]);
        if (!lk_vld_q) begin
            pred_pc = 13'h0000;
        end else if (pred_hit) begin
            pred_pc = rd_data_q[12:0];
        end else begin
            pred_pc = pc_q + 13'h0001;
        end
    end

    assign ready = (state_q == StRun);

endmodule

// File: tb/tb_btb_table.sv
module tb_btb_table;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        r_en;
    logic [12:0] r_pc;
    logic [12:0] pred_pc;
    logic        pred_hit;
    logic        ready;
    logic [15:0] w_data;
    logic [10:0] w_addr;
    logic        wen;

    btb_table dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .r_en     (r_en),
        .r_pc     (r_pc),
        .pred_pc  (pred_pc),
        .pred_hit (pred_hit),
        .ready    (ready),
        .w_data   (w_data),
        .w_addr   (w_addr),
        .wen      (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fails;

    // Reference model
    logic [15:0] m_tbl [2048];
    logic        m_run;
    int          m_cnt;
    logic        m_hold_hit;
    logic [12:0] m_hold_pc;
    logic [13:0] sb_q [$];  // {hit, pc}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run      = 1'b0;
        m_cnt      = 0;
        m_hold_hit = 1'b0;
        m_hold_pc  = 13'h0000;
        sb_q.delete();
    endtask

    // One clock cycle with the given inputs. Inputs are applied #1 after an edge.
    task automatic cycle(input logic cl, input logic we, input logic [10:0] wa,
                         input logic [15:0] wd, input logic re, input logic [12:0] rp);
        logic [15:0] e;
        logic        h;
        logic [12:0] p;
        logic [13:0] item;
        if (re) begin
            e = m_tbl[rp[10:0]];
`ifdef BTB_BYPASS_EN
            if (m_run && we && !cl && (wa == rp[10:0])) e = wd;
`endif
            h = m_run && e[15] && (e[14:13] == rp[12:11]);
            p = h ? e[12:0] : rp + 13'h0001;
            sb_q.push_back({h, p});
        end
        clear  = cl;
        wen    = we;
        w_addr = wa;
        w_data = wd;
        r_en   = re;
        r_pc   = rp;
        @(posedge clk);
        #1;
        // Model state update for the edge just taken
        if (cl) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (!m_run) begin
            m_tbl[m_cnt] = 16'h0000;
            if (m_cnt == 2047) begin
                m_run = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (we) begin
            m_tbl[wa] = wd;
        end
        if (re) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                item       = sb_q.pop_front();
                m_hold_hit = item[13];
                m_hold_pc  = item[12:0];
            end
        end
        check("ready", 32'(ready), 32'(m_run));
        check("pred_hit", 32'(pred_hit), 32'(m_hold_hit));
        check("pred_pc", 32'(pred_pc), 32'(m_hold_pc));
        clear = 1'b0;
        wen   = 1'b0;
        r_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 11'h0, 16'h0, 1'b0, 13'h0);
    endtask

    task automatic lookup(input logic [12:0] rp);
        cycle(1'b0, 1'b0, 11'h0, 16'h0, 1'b1, rp);
    endtask

    task automatic write(input logic [10:0] wa, input logic [15:0] wd);
        cycle(1'b0, 1'b1, wa, wd, 1'b0, 13'h0);
    endtask

    // Runs the sweep to completion. The number of cycles is bounded.
    task automatic finish_sweep();
        int guard;
        guard = 0;
        while (!m_run && guard < 5000) begin
            idle(1);
            guard++;
        end
        check("sweep_bound", 32'(m_run), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 2048; i++) m_tbl[i] = 16'h0000;
        rst_n  = 1'b0;
        clear  = 1'b0;
        r_en   = 1'b0;
        r_pc   = 13'h0;
        wen    = 1'b0;
        w_addr = 11'h0;
        w_data = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_pred_hit", 32'(pred_hit), 32'd0);
        check("rst_pred_pc", 32'(pred_pc), 32'd0);
        rst_n = 1'b1;

        // Initial sweep of 2048 cycles. The INIT lookups miss, and the INIT write is dropped.
        for (int i = 0; i < 2048; i++) begin
            if (i == 10) lookup(13'h0805);
            else if (i == 20) write(11'h005, 16'hA123);
            else if (i == 30) lookup(13'h1FFF);
            else idle(1);
        end
        check("ready_after_2048", 32'(ready), 32'd1);

        // Basic hit and miss
        write(11'h005, 16'hA123);
        lookup(13'h0805);
        check("hit_0805", 32'(pred_hit), 32'd1);
        check("pc_0805", 32'(pred_pc), 32'h0123);
        lookup(13'h1005);
        check("pc_1005", 32'(pred_pc), 32'h1006);
        idle(2);  // outputs hold
        lookup(13'h1FFF);
        check("wrap_pc", 32'(pred_pc), 32'h0000);
        write(11'h7FF, 16'hFABC);
        lookup(13'h1FFF);
        check("hit_1fff", 32'(pred_pc), 32'h1ABC);

        // Same-cycle write and lookup to an invalid entry
        cycle(1'b0, 1'b1, 11'h010, 16'h8040, 1'b1, 13'h0010);
`ifdef BTB_BYPASS_EN
        check("bypass_pc", 32'(pred_pc), 32'h0040);
`else
        check("bypass_pc", 32'(pred_pc), 32'h0011);
`endif
        lookup(13'h0010);
        check("after_bypass_hit", 32'(pred_hit), 32'd1);

        // A write with valid=0 invalidates the entry
        write(11'h005, 16'h2123);
        lookup(13'h0805);
        check("invalidated", 32'(pred_hit), 32'd0);

        // Clear together with wen: the write is dropped and the sweep restarts
        cycle(1'b1, 1'b1, 11'h020, 16'h8077, 1'b0, 13'h0);
        check("clear_ready", 32'(ready), 32'd0);
        idle(500);
        cycle(1'b1, 1'b0, 11'h0, 16'h0, 1'b1, 13'h0020);  // clear in INIT restarts the sweep
        finish_sweep();
        lookup(13'h0020);
        check("clear_dropped", 32'(pred_pc), 32'h0021);
        lookup(13'h0010);
        check("swept_miss", 32'(pred_hit), 32'd0);

        // Reset asserted mid-sweep
        write(11'h030, 16'h8055);
        cycle(1'b1, 1'b0, 11'h0, 16'h0, 1'b0, 13'h0);
        idle(998);
        lookup(13'h0456);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", 32'(ready), 32'd0);
        check("async_hit", 32'(pred_hit), 32'd0);
        check("async_pc", 32'(pred_pc), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2048; i++) idle(1);
        check("rerun_ready", 32'(ready), 32'd1);
        lookup(13'h0030);
        check("rerun_miss", 32'(pred_pc), 32'h0031);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
